// File: rtl/boreal_mem_pkg.sv
// boreal_mem_pkg: shared state encoding, update-mode constants and saturating add for the plastic RAM
package boreal_mem_pkg;

    typedef enum logic [2:0] {IDLE, RD, MOD, WR, CLR} state_t;

    localparam logic UPD_WRITE = 1'b0;
    localparam logic UPD_ADD   = 1'b1;

    // Width-generic saturating add: operands arrive sign-extended to 64 bits, result clipped to w bits
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] hi, lo, s;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s = a + b;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction

endpackage

// File: rtl/boreal_sat_add.sv
// boreal_sat_add: combinational signed (W+1)-bit add with clip to W bits and a clipped flag
module boreal_sat_add
    import boreal_mem_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         clip
);

    logic [W:0] s;

    always_comb begin
        s = {a[W-1], a} + {b[W-1], b};
        clip = s[W] ^ s[W-1];
        y = clip ? W'(sat_add(64'($signed(a)), 64'($signed(b)), W)) : s[W-1:0];
    end

endmodule

// File: rtl/boreal_plastic_ram.sv
// boreal_plastic_ram: synaptic weight RAM, 2-cycle read port A and read-modify-write plasticity port B
module boreal_plastic_ram
    import boreal_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic                  upd_mode,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic [DATA_WIDTH-1:0] upd_data,
    output logic                  sat_pulse,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    state_t st, nx;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_val, old_q, rd_q, sum;
    logic b_clip, clip, v1;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    end

`ifdef BOREAL_PLASTIC_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_addr;
    assign upd_ready = st == IDLE && !rst && !clear_req;
`else
    logic unused_clear;
    assign unused_clear = clear_req;
    assign upd_ready = st == IDLE && !rst;
`endif

    assign sat_pulse = st == WR && b_clip;
    assign busy = st != IDLE;

    boreal_sat_add #(.W(DATA_WIDTH)) u_add (.a(old_q), .b(b_val), .y(sum), .clip(clip));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else st <= nx;
    end

    always_comb begin
        nx = st;
        case (st)
            IDLE: nx = upd_valid && upd_ready ? (upd_mode == UPD_ADD ? RD : WR) : IDLE;
            RD: nx = MOD;
            MOD: nx = WR;
`ifdef BOREAL_PLASTIC_CLEAR_EN
            CLR: nx = &clr_addr ? IDLE : CLR;
`endif
            default: nx = IDLE;
        endcase
`ifdef BOREAL_PLASTIC_CLEAR_EN
        if (st == IDLE && clear_req) nx = CLR;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= '0;
            b_addr <= '0;
            b_val <= '0;
            b_clip <= 1'b0;
`ifdef BOREAL_PLASTIC_CLEAR_EN
            clr_addr <= '0;
`endif
        end else begin
            v1 <= rd_req;
            rd_valid <= v1;
            rd_data <= rd_q;
            if (upd_valid && upd_ready) begin
                b_addr <= upd_addr;
                b_val <= upd_data;
                b_clip <= 1'b0;
            end
            if (st == MOD) begin
                b_val <= sum;
                b_clip <= clip;
            end
`ifdef BOREAL_PLASTIC_CLEAR_EN
            clr_addr <= st == CLR ? clr_addr + 1'b1 : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rd_req) rd_q <= ram[rd_addr];
        if (st == RD) old_q <= ram[b_addr];
        if (st == WR) ram[b_addr] <= b_val;
`ifdef BOREAL_PLASTIC_CLEAR_EN
        else if (st == CLR) ram[clr_addr] <= '0;
`endif
    end

endmodule

// File: tb/tb_boreal_plastic_ram.sv
// tb_boreal_plastic_ram: scoreboard bench for the plastic weight RAM
module tb_boreal_plastic_ram;

`ifdef BOREAL_PLASTIC_CLEAR_EN
    localparam int AW = 4;
`else
    localparam int AW = 10;
`endif
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic clk = 0, rst = 1;
    logic rd_req = 0, rd_valid, upd_valid = 0, upd_ready, upd_mode = 0, sat_pulse, clear_req = 0, busy;
    logic [AW-1:0] rd_addr = '0, upd_addr = '0;
    logic [15:0] rd_data, upd_data = '0;
    logic [15:0] model [DEPTH];
    exp_t q[$];
    int cyc = 0, total = 0, bad = 0;

    boreal_plastic_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_mode(upd_mode),
        .upd_addr(upd_addr), .upd_data(upd_data), .sat_pulse(sat_pulse), .clear_req(clear_req),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            check("rd_valid", 32'(rd_valid), 1);
            check("rd_data", 32'(rd_data), 32'(q[0].data));
            q.delete(0);
        end else if (rd_valid) check("rd_spurious", 32'(rd_valid), 0);
    end

    task automatic rd(input logic [AW-1:0] a);
        exp_t e;
        e.due = cyc + 2;
        e.data = model[a];
        q.push_back(e);
        rd_req = 1;
        rd_addr = a;
        @(posedge clk); #1;
        rd_req = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    task automatic upd(input logic m, input logic [AW-1:0] a, input logic [15:0] d, input logic rdwr);
        int s;
        logic [15:0] v;
        logic sat;
        s = int'($signed(model[a])) + int'($signed(d));
        if (!m) begin v = d; sat = 0; end
        else if (s > 32767) begin v = 16'h7FFF; sat = 1; end
        else if (s < -32768) begin v = 16'h8000; sat = 1; end
        else begin v = 16'(s); sat = 0; end
        upd_valid = 1;
        upd_mode = m;
        upd_addr = a;
        upd_data = d;
        for (int i = 0; i < 50 && !upd_ready; i++) begin @(posedge clk); #1; end
        check("upd_ready", 32'(upd_ready), 1);
        @(posedge clk); #1;
        upd_valid = 0;
        if (m) repeat (2) begin
            check("ready_rmw", 32'(upd_ready), 0);
            @(posedge clk); #1;
        end
        check("ready_wr", 32'(upd_ready), 0);
        check("busy_wr", 32'(busy), 1);
        check("sat_pulse", 32'(sat_pulse), 32'(sat));
        if (rdwr) rd(a);
        else begin @(posedge clk); #1; end
        model[a] = v;
        check("ready_idle", 32'(upd_ready), 1);
        check("sat_idle", 32'(sat_pulse), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_upd_ready", 32'(upd_ready), 0);
        check("rst_sat", 32'(sat_pulse), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1 check("ready_after_rst", 32'(upd_ready), 1);
        @(posedge clk); #1;

        // reads and streaming
        upd(0, 5, 16'h1234, 0);
        upd(0, 3, 16'h0010, 0);
        upd(0, 7, 16'h7FF0, 0);
        upd(0, 8, 16'h8005, 0);
        rd(5);
        foreach (model[i]) if (i < 10) rd(AW'(i));
        drain();

        // add, saturation, zero delta
        upd(1, 3, 16'hFFF0, 0);
        upd(1, 7, 16'h0100, 0);
        upd(1, 8, 16'hFFF0, 0);
        upd(1, 8, 16'h0000, 0);
        upd(1, 5, 16'h0001, 0);
        rd(3); rd(7); rd(8); rd(5);
        drain();

        // serialised updates with a read-first collision
        upd(1, 9, 16'h0001, 1);
        upd(1, 9, 16'h0001, 0);
        rd(9);
        drain();

        // reset mid read-modify-write
        upd(0, 4, 16'h0040, 0);
        upd_valid = 1; upd_mode = 1; upd_addr = 4; upd_data = 16'h0005;
        @(posedge clk); #1;
        upd_valid = 0;
        @(posedge clk); #1;
        check("busy_mod", 32'(busy), 1);
        rst = 1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(upd_ready), 0);
        check("midrst_rd_valid", 32'(rd_valid), 0);
        check("midrst_rd_data", 32'(rd_data), 0);
        check("midrst_sat", 32'(sat_pulse), 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_ready", 32'(upd_ready), 1);
        rd(4);
        drain();

`ifdef BOREAL_PLASTIC_CLEAR_EN
        begin
            int n;
            n = 0;
            clear_req = 1;
            upd_valid = 1; upd_mode = 0; upd_addr = 2; upd_data = 16'h0055;
            #1 check("ready_vs_clear", 32'(upd_ready), 0);
            @(posedge clk); #1;
            clear_req = 0;
            for (int i = 0; i < 100 && busy; i++) begin
                check("clr_ready", 32'(upd_ready), 0);
                n++;
                @(posedge clk); #1;
            end
            check("clr_cycles", n, 16);
            check("ready_after_clr", 32'(upd_ready), 1);
            @(posedge clk); #1;
            upd_valid = 0;
            @(posedge clk); #1;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            model[2] = 16'h0055;
            for (int i = 0; i < DEPTH; i++) rd(AW'(i));
            drain();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
